wram_responder: RTL and testbench
=================================

WRAM_RESPONDER -- requirements
Module: wram_responder

Interface
REQ-001 SHALL have parameter WRAM_LO, default 16'hC000, meaning first address served on the WRAM slave port.
REQ-002 SHALL have parameter WRAM_HI, default 16'hE000, meaning exclusive upper bound of the WRAM slave port.
REQ-003 SHALL have parameter BANK_SPLIT, default 16'hD000, meaning first address of the switchable bank window.
REQ-004 SHALL have parameter SVBK_ADDR, default 16'hFF70, meaning the IO register address of the bank select register.
REQ-005 SHALL have port I_CLK  in  1  system clock; single clock domain; all state updates on rising edge.
REQ-006 SHALL have port I_RESET  in  1  reset; synchronous, active-high.
REQ-007 SHALL have port I_WRAM_ADDR  in  16  WRAM slave address from the memory router.
REQ-008 SHALL have port IO_WRAM_DATA  inout  8  WRAM slave data; write data in, read data out.
REQ-009 SHALL have port I_WRAM_WE_L  in  1  WRAM write strobe, active-low.
REQ-010 SHALL have port I_WRAM_RE_L  in  1  WRAM read strobe, active-low.
REQ-011 SHALL have port I_IOREG_ADDR  in  16  IO register bus address.
REQ-012 SHALL have port IO_IOREG_DATA  inout  8  IO register bus data.
REQ-013 SHALL have port I_IOREG_WE_L  in  1  IO register write strobe, active-low.
REQ-014 SHALL have port I_IOREG_RE_L  in  1  IO register read strobe, active-low.
REQ-015 SHALL have port O_RW_CONFLICT_ERROR  out  1  one-cycle pulse when WE_L and RE_L are both low on one port.

Function
REQ-016 SHALL respond on the WRAM port only when WRAM_LO <= I_WRAM_ADDR < WRAM_HI ("hit"); a miss SHALL cause no access, no drive and no error.
REQ-017 SHALL form a 15-bit physical address {bank[2:0], addr[11:0]}, with bank = 0 for addr < BANK_SPLIT, otherwise bank = (svbk == 0) ? 1 : svbk.
REQ-018 SHALL, on a rising edge with hit and WE_L=0, write IO_WRAM_DATA into the array at the physical address.
REQ-019 SHALL, on a rising edge with hit, RE_L=0 and WE_L=1, read the array and drive the result on IO_WRAM_DATA for exactly the following cycle; read latency is 1 cycle.
REQ-020 SHALL hold IO_WRAM_DATA at high-Z in every cycle not covered by REQ-019.
REQ-021 SHALL treat WE_L=0 and RE_L=0 together on a hit as a write only: no read drive, and O_RW_CONFLICT_ERROR high for the next cycle.
REQ-022 SHALL, on a rising edge with I_IOREG_ADDR == SVBK_ADDR and IOREG WE_L=0, load svbk with IO_IOREG_DATA[2:0].
REQ-023 SHALL, on an SVBK read (RE_L=0, WE_L=1), drive {5'b11111, svbk} on IO_IOREG_DATA for exactly the following cycle; otherwise IO_IOREG_DATA SHALL be high-Z.
REQ-024 SHALL apply the REQ-021 conflict rule to the SVBK port; O_RW_CONFLICT_ERROR SHALL be the OR of both ports' conflicts.
REQ-025 SHALL decode a WRAM access in the same cycle as an SVBK write with the old svbk value; the new bank takes effect from the next edge.
REQ-026 SHALL support back-to-back reads on consecutive cycles, with each result driven in the cycle after its own strobe.
REQ-027 SHALL return the written byte on a read one cycle after a write to the same address (no stale data).
REQ-028 SHALL wrap address bits [11:0] within each 4 KB bank, with no carry into bank bits.

Reset
REQ-029 SHALL, while I_RESET=1 at an edge: set svbk to 0, clear both read-drive enables (both data buses high-Z next cycle) and set O_RW_CONFLICT_ERROR to 0.
REQ-030 SHALL ignore strobes during a reset cycle; a read sampled the cycle before reset SHALL still drive in the reset cycle but not after it.
REQ-031 SHALL NOT clear array contents on reset.

Structure
REQ-032 SHALL take the WRAM_LO/WRAM_HI/SVBK_ADDR values from the shared memdef.vh defines, not from local literals.
REQ-033 SHALL contain one sub-module, wram_bank_array: 32K x 8, single port, synchronous write, registered read, inferable as block RAM.
REQ-034 SHALL keep bank decode, strobe qualification, drive enables and the error flag in wram_responder.

Verification
REQ-035 SHALL verify: write 8'hA5 @C123, read @C123 -> IO_WRAM_DATA=8'hA5 one cycle later, high-Z the cycle after.
REQ-036 SHALL verify: SVBK=0, write 8'h11 @D000; SVBK=3, write 8'h33 @D000; SVBK=1, read @D000 -> 8'h11; SVBK=3, read -> 8'h33.
REQ-037 SHALL verify: SVBK write 8'hFE, then SVBK read -> IO_IOREG_DATA=8'hFE; reset, then read -> 8'hF8 and bank 1 decode.
REQ-038 SHALL verify: WE_L=RE_L=0 @C000 with data 8'h5A -> no drive, error pulse one cycle, later read @C000 -> 8'h5A.
REQ-039 SHALL verify: read @E000 and @BFFF -> bus stays high-Z, no error; reads @C000..C003 back-to-back -> four consecutive valid data cycles.

Source files
------------

// File: rtl/wram_responder_pkg.sv
// Shared memory-map constants, access decode and bank decode for the WRAM responder.
package wram_responder_pkg;

  // Memory-map values that memdef.vh used to supply as defines
  localparam logic [15:0] MEM_WRAM_LO    = 16'hC000;
  localparam logic [15:0] MEM_WRAM_HI    = 16'hE000;
  localparam logic [15:0] MEM_BANK_SPLIT = 16'hD000;
  localparam logic [15:0] MEM_SVBK_ADDR  = 16'hFF70;

  // Physical array address width: 3 bank bits + 12 offset bits
  localparam int unsigned PHYS_AW = 15;

  typedef enum logic [1:0] {
    ACC_NONE,
    ACC_READ,
    ACC_WRITE,
    ACC_CONFLICT
  } access_t;

  // Classify a pair of active-low strobes
  function automatic access_t decode_access(input logic we_l, input logic re_l);
    access_t acc;
    unique case ({we_l, re_l})
      2'b00:   acc = ACC_CONFLICT;
      2'b01:   acc = ACC_WRITE;
      2'b10:   acc = ACC_READ;
      default: acc = ACC_NONE;
    endcase
    return acc;
  endfunction

  // Fixed bank 0 below the split; above it, svbk with 0 aliased to bank 1
  function automatic logic [2:0] bank_of(input logic [15:0] addr,
                                         input logic [15:0] split,
                                         input logic [2:0]  svbk);
    if (addr < split)
      return 3'd0;
    else if (svbk == 3'd0)
      return 3'd1;
    else
      return svbk;
  endfunction

endpackage

// File: rtl/wram_bank_array.sv
// 32K x 8 single-port WRAM storage: synchronous write, registered read.
module wram_bank_array
  import wram_responder_pkg::*;
(
  input  logic               clk,
  input  logic               we,
  input  logic               re,
  input  logic [PHYS_AW-1:0] addr,
  input  logic [7:0]         wdata,
  output logic [7:0]         rdata
);

  logic [7:0] mem [0:(1 << PHYS_AW) - 1];

  // Single port: a write takes the port, otherwise a read registers the addressed byte
  always_ff @(posedge clk) begin
    if (we)
      mem[addr] <= wdata;
    else if (re)
      rdata <= mem[addr];
  end

endmodule

// File: rtl/wram_responder.sv
// WRAM slave responder: address hit and bank decode, SVBK register,
// one-cycle read drive on both tristate buses and read/write conflict flag.
module wram_responder
  import wram_responder_pkg::*;
#(
  parameter logic [15:0] WRAM_LO    = MEM_WRAM_LO,
  parameter logic [15:0] WRAM_HI    = MEM_WRAM_HI,
  parameter logic [15:0] BANK_SPLIT = MEM_BANK_SPLIT,
  parameter logic [15:0] SVBK_ADDR  = MEM_SVBK_ADDR
) (
  input  logic        I_CLK,
  input  logic        I_RESET,
  input  logic [15:0] I_WRAM_ADDR,
  inout  wire  [7:0]  IO_WRAM_DATA,
  input  logic        I_WRAM_WE_L,
  input  logic        I_WRAM_RE_L,
  input  logic [15:0] I_IOREG_ADDR,
  inout  wire  [7:0]  IO_IOREG_DATA,
  input  logic        I_IOREG_WE_L,
  input  logic        I_IOREG_RE_L,
  output logic        O_RW_CONFLICT_ERROR
);

  access_t            wram_acc;
  access_t            svbk_acc;
  logic               wram_hit;
  logic               svbk_hit;
  logic [2:0]         svbk;
  logic [2:0]         bank;
  logic [PHYS_AW-1:0] phys;
  logic               arr_we;
  logic               arr_re;
  logic [7:0]         arr_rdata;
  logic               wram_drive;
  logic               ioreg_drive;
  logic [7:0]         ioreg_rdata;

  // Decode hits, strobes and physical address; a conflict counts as a write only
  always_comb begin
    wram_hit = (I_WRAM_ADDR >= WRAM_LO) && (I_WRAM_ADDR < WRAM_HI);
    svbk_hit = (I_IOREG_ADDR == SVBK_ADDR);
    wram_acc = decode_access(I_WRAM_WE_L, I_WRAM_RE_L);
    svbk_acc = decode_access(I_IOREG_WE_L, I_IOREG_RE_L);
    bank     = bank_of(I_WRAM_ADDR, BANK_SPLIT, svbk);
    phys     = {bank, I_WRAM_ADDR[11:0]};
    arr_we   = !I_RESET && wram_hit &&
               ((wram_acc == ACC_WRITE) || (wram_acc == ACC_CONFLICT));
    arr_re   = !I_RESET && wram_hit && (wram_acc == ACC_READ);
  end

  wram_bank_array u_array (
    .clk   (I_CLK),
    .we    (arr_we),
    .re    (arr_re),
    .addr  (phys),
    .wdata (IO_WRAM_DATA),
    .rdata (arr_rdata)
  );

  // Bank register, read-drive enables and conflict flag; the bank decode above
  // uses the pre-edge svbk, so a same-cycle SVBK write affects the next access
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      svbk                <= '0;
      wram_drive          <= 1'b0;
      ioreg_drive         <= 1'b0;
      O_RW_CONFLICT_ERROR <= 1'b0;
    end else begin
      if (svbk_hit && ((svbk_acc == ACC_WRITE) || (svbk_acc == ACC_CONFLICT)))
        svbk <= IO_IOREG_DATA[2:0];
      wram_drive          <= arr_re;
      ioreg_drive         <= svbk_hit && (svbk_acc == ACC_READ);
      O_RW_CONFLICT_ERROR <= (wram_hit && (wram_acc == ACC_CONFLICT)) ||
                             (svbk_hit && (svbk_acc == ACC_CONFLICT));
    end
  end

  // Capture the SVBK readback byte; only visible while ioreg_drive is set
  always_ff @(posedge I_CLK) begin
    if (svbk_hit && (svbk_acc == ACC_READ))
      ioreg_rdata <= {5'b11111, svbk};
  end

  assign IO_WRAM_DATA  = wram_drive  ? arr_rdata   : 'z;
  assign IO_IOREG_DATA = ioreg_drive ? ioreg_rdata : 'z;

endmodule

// File: tb/tb_wram_responder.sv
// Directed self-checking bench for wram_responder. The bench keeps its own
// driver on each data bus: it drives write data or a 8'h00 probe whenever the
// DUT must stay off the bus, and releases it only in cycles where read data is
// expected, so an unwanted DUT drive shows up as a non-probe value.
module tb_wram_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] w_addr;
  logic        w_we_l;
  logic        w_re_l;
  logic        w_drv_en;
  logic [7:0]  w_drv;
  logic [15:0] i_addr;
  logic        i_we_l;
  logic        i_re_l;
  logic        i_drv_en;
  logic [7:0]  i_drv;
  logic        err;
  wire  [7:0]  wram_bus;
  wire  [7:0]  io_bus;

  int n_checks = 0;
  int n_fail   = 0;

  assign wram_bus = w_drv_en ? w_drv : 8'hzz;
  assign io_bus   = i_drv_en ? i_drv : 8'hzz;

  always #5 clk = ~clk;

  wram_responder #(
    .WRAM_LO    (16'hC000),
    .WRAM_HI    (16'hE000),
    .BANK_SPLIT (16'hD000),
    .SVBK_ADDR  (16'hFF70)
  ) dut (
    .I_CLK               (clk),
    .I_RESET             (rst),
    .I_WRAM_ADDR         (w_addr),
    .IO_WRAM_DATA        (wram_bus),
    .I_WRAM_WE_L         (w_we_l),
    .I_WRAM_RE_L         (w_re_l),
    .I_IOREG_ADDR        (i_addr),
    .IO_IOREG_DATA       (io_bus),
    .I_IOREG_WE_L        (i_we_l),
    .I_IOREG_RE_L        (i_re_l),
    .O_RW_CONFLICT_ERROR (err)
  );

  task automatic drive_w(input logic [15:0] a, input logic we_l, input logic re_l,
                         input logic [7:0] d, input logic en);
    w_addr = a; w_we_l = we_l; w_re_l = re_l; w_drv = d; w_drv_en = en;
  endtask

  task automatic drive_i(input logic [15:0] a, input logic we_l, input logic re_l,
                         input logic [7:0] d, input logic en);
    i_addr = a; i_we_l = we_l; i_re_l = re_l; i_drv = d; i_drv_en = en;
  endtask

  task automatic idle();
    drive_w(16'h0000, 1'b1, 1'b1, 8'h00, 1'b1);
    drive_i(16'h0000, 1'b1, 1'b1, 8'h00, 1'b1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    tick();
    tick();
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
    n_checks++;
    if (wram_bus !== 8'h00) begin n_fail++; $display("FAIL reset_wram_z: got %h expected %h", wram_bus, 8'h00); end
    n_checks++;
    if (io_bus !== 8'h00) begin n_fail++; $display("FAIL reset_io_z: got %h expected %h", io_bus, 8'h00); end
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    idle(); tick();
    idle(); drive_w(16'hC123, 1'b0, 1'b1, 8'hA5, 1'b1); tick();
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL wr_no_err: got %b expected 0", err); end
    idle(); drive_w(16'hC123, 1'b1, 1'b0, 8'h00, 1'b0); tick();
    n_checks++;
    if (wram_bus !== 8'hA5) begin n_fail++; $display("FAIL rd_c123: got %h expected %h", wram_bus, 8'hA5); end
    idle(); tick();
    n_checks++;
    if (wram_bus !== 8'h00) begin n_fail++; $display("FAIL rd_c123_release: got %h expected %h", wram_bus, 8'h00); end
  endtask

  task automatic test_bank_select();
    idle(); tick();
    idle(); drive_i(16'hFF70, 1'b0, 1'b1, 8'h00, 1'b1); tick();
    idle(); drive_w(16'hD000, 1'b0, 1'b1, 8'h11, 1'b1); tick();
    idle(); drive_i(16'hFF70, 1'b0, 1'b1, 8'h03, 1'b1); tick();
    idle(); drive_w(16'hD000, 1'b0, 1'b1, 8'h33, 1'b1); tick();
    idle(); drive_i(16'hFF70, 1'b0, 1'b1, 8'h01, 1'b1); tick();
    idle(); drive_w(16'hD000, 1'b1, 1'b0, 8'h00, 1'b0); tick();
    n_checks++;
    if (wram_bus !== 8'h11) begin n_fail++; $display("FAIL bank1_read: got %h expected %h", wram_bus, 8'h11); end
    idle(); drive_i(16'hFF70, 1'b0, 1'b1, 8'h03, 1'b1); tick();
    idle(); drive_w(16'hD000, 1'b1, 1'b0, 8'h00, 1'b0); tick();
    n_checks++;
    if (wram_bus !== 8'h33) begin n_fail++; $display("FAIL bank3_read: got %h expected %h", wram_bus, 8'h33); end
  endtask

  task automatic test_svbk_reg();
    idle(); tick();
    idle(); drive_i(16'hFF70, 1'b0, 1'b1, 8'hFE, 1'b1); tick();
    idle(); drive_i(16'hFF70, 1'b1, 1'b0, 8'h00, 1'b0); tick();
    n_checks++;
    if (io_bus !== 8'hFE) begin n_fail++; $display("FAIL svbk_read_fe: got %h expected %h", io_bus, 8'hFE); end
    idle(); tick();
    n_checks++;
    if (io_bus !== 8'h00) begin n_fail++; $display("FAIL svbk_release: got %h expected %h", io_bus, 8'h00); end
    rst = 1'b1; idle(); tick();
    rst = 1'b0;
    idle(); drive_i(16'hFF70, 1'b1, 1'b0, 8'h00, 1'b0); tick();
    n_checks++;
    if (io_bus !== 8'hF8) begin n_fail++; $display("FAIL svbk_after_reset: got %h expected %h", io_bus, 8'hF8); end
    idle(); drive_w(16'hD000, 1'b1, 1'b0, 8'h00, 1'b0); tick();
    n_checks++;
    if (wram_bus !== 8'h11) begin n_fail++; $display("FAIL bank1_after_reset: got %h expected %h", wram_bus, 8'h11); end
  endtask

  task automatic test_same_cycle_bank();
    idle(); tick();
    idle();
    drive_i(16'hFF70, 1'b0, 1'b1, 8'h03, 1'b1);
    drive_w(16'hD000, 1'b1, 1'b0, 8'h00, 1'b0);
    tick();
    n_checks++;
    if (wram_bus !== 8'h11) begin n_fail++; $display("FAIL same_cycle_old_bank: got %h expected %h", wram_bus, 8'h11); end
    idle(); drive_w(16'hD000, 1'b1, 1'b0, 8'h00, 1'b0); tick();
    n_checks++;
    if (wram_bus !== 8'h33) begin n_fail++; $display("FAIL next_cycle_new_bank: got %h expected %h", wram_bus, 8'h33); end
  endtask

  task automatic test_conflict();
    idle(); tick();
    idle(); drive_w(16'hC000, 1'b0, 1'b0, 8'h5A, 1'b1); tick();
    n_checks++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL wram_conflict_err: got %b expected 1", err); end
    n_checks++;
    if (wram_bus !== 8'h5A) begin n_fail++; $display("FAIL wram_conflict_nodrive: got %h expected %h", wram_bus, 8'h5A); end
    idle(); tick();
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL wram_conflict_pulse: got %b expected 0", err); end
    idle(); drive_w(16'hC000, 1'b1, 1'b0, 8'h00, 1'b0); tick();
    n_checks++;
    if (wram_bus !== 8'h5A) begin n_fail++; $display("FAIL conflict_write_kept: got %h expected %h", wram_bus, 8'h5A); end
    idle(); drive_i(16'hFF70, 1'b0, 1'b0, 8'h05, 1'b1); tick();
    n_checks++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL svbk_conflict_err: got %b expected 1", err); end
    n_checks++;
    if (io_bus !== 8'h05) begin n_fail++; $display("FAIL svbk_conflict_nodrive: got %h expected %h", io_bus, 8'h05); end
    idle(); tick();
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL svbk_conflict_pulse: got %b expected 0", err); end
    idle(); drive_i(16'hFF70, 1'b1, 1'b0, 8'h00, 1'b0); tick();
    n_checks++;
    if (io_bus !== 8'hFD) begin n_fail++; $display("FAIL svbk_conflict_written: got %h expected %h", io_bus, 8'hFD); end
  endtask

  // svbk is 5 on entry
  task automatic test_miss_and_wrap();
    idle(); tick();
    idle(); drive_w(16'hCFFF, 1'b0, 1'b1, 8'h3C, 1'b1); tick();
    idle(); drive_w(16'hD000, 1'b0, 1'b1, 8'h4B, 1'b1); tick();
    idle(); drive_w(16'hDFFF, 1'b0, 1'b1, 8'hE5, 1'b1); tick();
    idle(); drive_w(16'hE000, 1'b1, 1'b0, 8'h00, 1'b1); tick();
    n_checks++;
    if (wram_bus !== 8'h00) begin n_fail++; $display("FAIL miss_e000_z: got %h expected %h", wram_bus, 8'h00); end
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL miss_e000_err: got %b expected 0", err); end
    idle(); drive_w(16'hBFFF, 1'b1, 1'b0, 8'h00, 1'b1); tick();
    n_checks++;
    if (wram_bus !== 8'h00) begin n_fail++; $display("FAIL miss_bfff_z: got %h expected %h", wram_bus, 8'h00); end
    idle(); drive_w(16'hE000, 1'b0, 1'b0, 8'h99, 1'b1); tick();
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL miss_conflict_err: got %b expected 0", err); end
    idle(); drive_w(16'hD000, 1'b1, 1'b0, 8'h00, 1'b0); tick();
    n_checks++;
    if (wram_bus !== 8'h4B) begin n_fail++; $display("FAIL miss_no_write: got %h expected %h", wram_bus, 8'h4B); end
    idle(); drive_w(16'hDFFF, 1'b1, 1'b0, 8'h00, 1'b0); tick();
    n_checks++;
    if (wram_bus !== 8'hE5) begin n_fail++; $display("FAIL bank_top_dfff: got %h expected %h", wram_bus, 8'hE5); end
    idle(); drive_w(16'hCFFF, 1'b1, 1'b0, 8'h00, 1'b0); tick();
    n_checks++;
    if (wram_bus !== 8'h3C) begin n_fail++; $display("FAIL bank0_top_cfff: got %h expected %h", wram_bus, 8'h3C); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pat [4];
    pat = '{8'h10, 8'h21, 8'h32, 8'h43};
    idle(); tick();
    for (int i = 0; i < 4; i++) begin
      idle(); drive_w(16'hC000 + 16'(i), 1'b0, 1'b1, pat[i], 1'b1); tick();
    end
    for (int i = 0; i < 4; i++) begin
      idle(); drive_w(16'hC000 + 16'(i), 1'b1, 1'b0, 8'h00, 1'b0); tick();
      n_checks++;
      if (wram_bus !== pat[i]) begin
        n_fail++; $display("FAIL b2b_read_%0d: got %h expected %h", i, wram_bus, pat[i]);
      end
    end
    idle(); tick();
    n_checks++;
    if (wram_bus !== 8'h00) begin n_fail++; $display("FAIL b2b_release: got %h expected %h", wram_bus, 8'h00); end
  endtask

  task automatic test_reset_during_read();
    idle(); tick();
    idle(); drive_w(16'hC001, 1'b1, 1'b0, 8'h00, 1'b0); tick();
    n_checks++;
    if (wram_bus !== 8'h21) begin n_fail++; $display("FAIL pre_reset_read: got %h expected %h", wram_bus, 8'h21); end
    rst = 1'b1;
    idle();
    drive_w(16'hC002, 1'b0, 1'b1, 8'hEE, 1'b1);
    drive_i(16'hFF70, 1'b0, 1'b0, 8'h07, 1'b1);
    tick();
    n_checks++;
    if (wram_bus !== 8'hEE) begin n_fail++; $display("FAIL reset_drive_cleared: got %h expected %h", wram_bus, 8'hEE); end
    n_checks++;
    if (io_bus !== 8'h07) begin n_fail++; $display("FAIL reset_io_nodrive: got %h expected %h", io_bus, 8'h07); end
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL reset_conflict_ignored: got %b expected 0", err); end
    rst = 1'b0;
    idle(); drive_w(16'hC002, 1'b1, 1'b0, 8'h00, 1'b0); tick();
    n_checks++;
    if (wram_bus !== 8'h32) begin n_fail++; $display("FAIL reset_write_ignored: got %h expected %h", wram_bus, 8'h32); end
    idle(); drive_i(16'hFF70, 1'b1, 1'b0, 8'h00, 1'b0); tick();
    n_checks++;
    if (io_bus !== 8'hF8) begin n_fail++; $display("FAIL reset_svbk_ignored: got %h expected %h", io_bus, 8'hF8); end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_write_read();
    test_bank_select();
    test_svbk_reg();
    test_same_cycle_bank();
    test_conflict();
    test_miss_and_wrap();
    test_back_to_back();
    test_reset_during_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
